lfsr_checker: RTL and testbench

- Receive-side counterpart of the 8-bit LFSR pattern generator. Takes the serial bit stream that the generator emits (its shift-register bit 0 each step) and self-synchronises to it.
- Once synchronised, checks every bit against the predicted sequence and counts errors.
- Shows the error count as two hex digits on the board's active-low 7-segment displays. Used for link and loopback testing on the board.

---
 rtl/lfsr_pkg.sv | 29 ++
 rtl/lfsr_checker_hex7seg.sv | 14 +
 rtl/lfsr_checker.sv | 120 ++++++++++++
 tb/tb_lfsr_checker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants for the 8-bit LFSR pattern generator and checker.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 8;

    // Feedback taps for b[n+8] = b[n+4] ^ b[n+3] ^ b[n+2] ^ b[n]
    localparam int unsigned TAP_A = 4;
    localparam int unsigned TAP_B = 3;
    localparam int unsigned TAP_C = 2;
    localparam int unsigned TAP_D = 0;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Active-low 7-segment codes, bit6=a .. bit0=g
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    // Next stream bit predicted from a window whose bit 0 is the oldest bit
    function automatic logic lfsr_predict(input logic [LFSR_W-1:0] w);
        return w[TAP_A] ^ w[TAP_B] ^ w[TAP_C] ^ w[TAP_D];
    endfunction

endpackage

// File: rtl/lfsr_checker_hex7seg.sv
// Hex digit to active-low 7-segment lookup.
module hex7seg
    import lfsr_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_c
);

    // Pure table lookup
    always_comb begin
        seg_c = SEG_LUT[digit];
    end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 8-bit LFSR serial test pattern.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned VERIFY_LEN  = 8,
    parameter int unsigned LOSS_THRESH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       clr_err,
    output logic       locked,
    output logic       err_pulse,
    output logic [7:0] err_cnt,
    output logic [6:0] SEG1,
    output logic [6:0] SEG0
);

    state_t              state;
    logic [LFSR_W-1:0]   win;
    logic [2:0]          seed_cnt;
    logic [7:0]          ver_cnt;
    logic [3:0]          miss_cnt;
    logic                pred_c;
    logic [LFSR_W-1:0]   win_in_c;
    logic [LFSR_W-1:0]   win_fly_c;

    // Prediction and the two candidate window updates
    always_comb begin
        pred_c    = lfsr_predict(win);
        win_in_c  = {bit_in, win[LFSR_W-1:1]};
        win_fly_c = {pred_c, win[LFSR_W-1:1]};
    end

    // Acquisition / tracking state machine with registered status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= SEED;
            win       <= '0;
            seed_cnt  <= '0;
            ver_cnt   <= '0;
            miss_cnt  <= '0;
            err_cnt   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (bit_valid) begin
                case (state)
                    SEED: begin
                        win <= win_in_c;
                        if (seed_cnt == 3'd7) begin
                            seed_cnt <= '0;
                            // An all-zero window would lock onto the dead LFSR state
                            if (win_in_c != '0) begin
                                state   <= VERIFY;
                                ver_cnt <= '0;
                            end
                        end else begin
                            seed_cnt <= seed_cnt + 3'd1;
                        end
                    end
                    VERIFY: begin
                        win <= win_in_c;
                        if (bit_in == pred_c) begin
                            ver_cnt <= ver_cnt + 8'd1;
                            if (ver_cnt == 8'(VERIFY_LEN - 1)) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else begin
                            state    <= SEED;
                            seed_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: track the prediction so one bad bit costs one error
                        win <= win_fly_c;
                        if (bit_in != pred_c) begin
                            err_pulse <= 1'b1;
                            miss_cnt  <= miss_cnt + 4'd1;
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                            if (miss_cnt == 4'(LOSS_THRESH - 1)) begin
                                state    <= SEED;
                                seed_cnt <= '0;
                                locked   <= 1'b0;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= SEED;
                        seed_cnt <= '0;
                        locked   <= 1'b0;
                    end
                endcase
            end
            // Clear takes priority over a same-cycle increment
            if (clr_err) begin
                err_cnt <= '0;
            end
        end
    end

    hex7seg u_seg1 (
        .digit (err_cnt[7:4]),
        .seg_c (SEG1)
    );

    hex7seg u_seg0 (
        .digit (err_cnt[3:0]),
        .seg_c (SEG0)
    );

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed scenarios plus randomized traffic against a stream-level model.
module tb_lfsr_checker;

    localparam int unsigned VLEN = 8;
    localparam int unsigned LTH  = 3;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       clr_err;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [6:0] SEG1;
    logic [6:0] SEG0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] seg_ref [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    lfsr_checker #(.VERIFY_LEN(VLEN), .LOSS_THRESH(LTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .clr_err   (clr_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .SEG1      (SEG1),
        .SEG0      (SEG0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern source: upcoming stream bits b[n..n+7], extended by the recurrence
    bit gq[$];

    task automatic gen_seed(input logic [7:0] s);
        gq.delete();
        for (int i = 0; i < 8; i++) gq.push_back(s[i]);
    endtask

    task automatic gen_next(output logic o);
        bit nb;
        o  = gq[0];
        nb = gq[0] ^ gq[2] ^ gq[3] ^ gq[4];
        void'(gq.pop_front());
        gq.push_back(nb);
    endtask

    // Reference model: history of the last 8 bits the checker believes in
    bit m_q[$];
    int m_mode;   // 0 acquiring seed, 1 verifying, 2 locked
    int m_seed, m_ver, m_miss, m_err;
    bit m_locked, m_pulse;

    task automatic model_step(input bit r, input bit v, input bit b, input bit c);
        bit p;
        bit allz;
        if (!r) begin
            m_q.delete();
            for (int i = 0; i < 8; i++) m_q.push_back(1'b0);
            m_mode = 0; m_seed = 0; m_ver = 0; m_miss = 0; m_err = 0;
            m_locked = 0; m_pulse = 0;
            return;
        end
        m_pulse = 0;
        if (v) begin
            p = m_q[0] ^ m_q[2] ^ m_q[3] ^ m_q[4];
            if (m_mode == 0) begin
                void'(m_q.pop_front()); m_q.push_back(b);
                m_seed++;
                if (m_seed == 8) begin
                    m_seed = 0;
                    allz = 1;
                    foreach (m_q[i]) if (m_q[i]) allz = 0;
                    if (!allz) begin m_mode = 1; m_ver = 0; end
                end
            end else if (m_mode == 1) begin
                void'(m_q.pop_front()); m_q.push_back(b);
                if (b == p) begin
                    m_ver++;
                    if (m_ver == VLEN) begin m_mode = 2; m_miss = 0; m_locked = 1; end
                end else begin
                    m_mode = 0; m_seed = 0;
                end
            end else begin
                void'(m_q.pop_front()); m_q.push_back(p);
                if (b != p) begin
                    m_pulse = 1;
                    if (m_err < 255) m_err++;
                    m_miss++;
                    if (m_miss == LTH) begin m_mode = 0; m_seed = 0; m_locked = 0; end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (c) m_err = 0;
    endtask

    // Drive one cycle, update the model, sample 1 time unit after the edge
    task automatic step(input logic r, input logic v, input logic b, input logic c);
        rst = r; bit_valid = v; bit_in = b; clr_err = c;
        @(posedge clk);
        model_step(r, v, b, c);
        #1;
    endtask

    // Send the next pattern bit, optionally inverted
    task automatic send(input bit inv);
        logic g;
        gen_next(g);
        step(1'b1, 1'b1, g ^ inv, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else n_pass++;
        n_checks++; if (err_pulse !== 1'b0) $display("FAIL reset_pulse: got %b want 0", err_pulse); else n_pass++;
        n_checks++; if (err_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", err_cnt); else n_pass++;
        n_checks++; if (SEG1 !== 7'h01 || SEG0 !== 7'h01)
            $display("FAIL reset_seg: got %h/%h want 01/01", SEG1, SEG0); else n_pass++;
    endtask

    task automatic test_lock();
        gen_seed(8'h01);
        for (int i = 1; i <= 16; i++) begin
            send(1'b0);
            n_checks++; if (locked !== (i == 16)) $display("FAIL lock_seq bit %0d: got %b want %b", i, locked, (i == 16)); else n_pass++;
        end
        n_checks++; if (err_cnt !== 8'd0) $display("FAIL lock_cnt: got %0d want 0", err_cnt); else n_pass++;
        n_checks++; if (SEG1 !== 7'h01 || SEG0 !== 7'h01)
            $display("FAIL lock_seg: got %h/%h want 01/01", SEG1, SEG0); else n_pass++;
    endtask

    task automatic test_single_error();
        for (int i = 0; i < 5; i++) begin
            send(1'b0);
            n_checks++; if (err_pulse !== 1'b0 || locked !== 1'b1)
                $display("FAIL single_clean %0d: pulse=%b locked=%b want 0/1", i, err_pulse, locked); else n_pass++;
        end
        send(1'b1);
        n_checks++; if (err_pulse !== 1'b1) $display("FAIL single_pulse: got %b want 1", err_pulse); else n_pass++;
        n_checks++; if (err_cnt !== 8'd1) $display("FAIL single_cnt: got %0d want 1", err_cnt); else n_pass++;
        n_checks++; if (SEG0 !== 7'h4F || SEG1 !== 7'h01)
            $display("FAIL single_seg: got %h/%h want 01/4f", SEG1, SEG0); else n_pass++;
        n_checks++; if (locked !== 1'b1) $display("FAIL single_locked: got %b want 1", locked); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            send(1'b0);
            n_checks++; if (err_pulse !== 1'b0 || err_cnt !== 8'd1)
                $display("FAIL single_after %0d: pulse=%b cnt=%0d want 0/1", i, err_pulse, err_cnt); else n_pass++;
        end
    endtask

    task automatic test_loss_of_lock();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++; if (err_cnt !== 8'd0 || locked !== 1'b1)
            $display("FAIL loss_clr: cnt=%0d locked=%b want 0/1", err_cnt, locked); else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            send(1'b1);
            n_checks++; if (locked !== (k < 3) || err_cnt !== 8'(k) || err_pulse !== 1'b1)
                $display("FAIL loss_miss %0d: locked=%b cnt=%0d pulse=%b want %b/%0d/1",
                         k, locked, err_cnt, err_pulse, (k < 3), k); else n_pass++;
        end
        for (int i = 1; i <= 16; i++) begin
            send(1'b0);
            n_checks++; if (locked !== (i == 16)) $display("FAIL relock bit %0d: got %b want %b", i, locked, (i == 16)); else n_pass++;
        end
        n_checks++; if (err_cnt !== 8'd3) $display("FAIL relock_cnt: got %0d want 3", err_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_verify();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) send(1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++; if (locked !== 1'b0 || err_cnt !== 8'd0)
            $display("FAIL midrst: locked=%b cnt=%0d want 0/0", locked, err_cnt); else n_pass++;
        for (int i = 1; i <= 16; i++) begin
            send(1'b0);
            n_checks++; if (locked !== (i == 16)) $display("FAIL midrst_relock bit %0d: got %b want %b", i, locked, (i == 16)); else n_pass++;
        end
    endtask

    task automatic test_zero_stream();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            n_checks++; if (locked !== 1'b0) $display("FAIL zero_locked bit %0d: got %b want 0", i, locked); else n_pass++;
        end
        n_checks++; if (m_mode != 0) $display("FAIL zero_model_mode: got %0d want 0", m_mode); else n_pass++;
        gen_seed(8'($urandom_range(1, 255)));
        for (int i = 1; i <= 16; i++) begin
            send(1'b0);
            n_checks++; if (locked !== (i == 16)) $display("FAIL zero_then_lock bit %0d: got %b want %b", i, locked, (i == 16)); else n_pass++;
        end
    endtask

    task automatic test_saturation_clear_gaps();
        logic g;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        gen_seed(8'($urandom_range(1, 255)));
        for (int i = 0; i < 16; i++) send(1'b0);
        n_checks++; if (locked !== 1'b1) $display("FAIL sat_lock: got %b want 1", locked); else n_pass++;
        for (int e = 0; e < 300; e++) begin
            for (int ph = 0; ph < 4; ph++) begin
                if (ph == 0 || ph == 2) begin
                    gen_next(g);
                    step(1'b1, 1'b1, g ^ (ph == 0), 1'b0);
                end else begin
                    step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
                end
                n_checks++; if (err_pulse !== m_pulse || err_cnt !== 8'(m_err))
                    $display("FAIL sat_track e%0d ph%0d: pulse=%b cnt=%0d want %b/%0d",
                             e, ph, err_pulse, err_cnt, m_pulse, m_err); else n_pass++;
            end
        end
        n_checks++; if (err_cnt !== 8'd255) $display("FAIL sat_cnt: got %0d want 255", err_cnt); else n_pass++;
        n_checks++; if (SEG1 !== 7'h38 || SEG0 !== 7'h38)
            $display("FAIL sat_seg: got %h/%h want 38/38", SEG1, SEG0); else n_pass++;
        n_checks++; if (locked !== 1'b1) $display("FAIL sat_locked: got %b want 1", locked); else n_pass++;
        gen_next(g);
        step(1'b1, 1'b1, ~g, 1'b1);
        n_checks++; if (err_cnt !== 8'd0 || err_pulse !== 1'b1)
            $display("FAIL clr_vs_err: cnt=%0d pulse=%b want 0/1", err_cnt, err_pulse); else n_pass++;
        n_checks++; if (SEG1 !== 7'h01 || SEG0 !== 7'h01)
            $display("FAIL clr_seg: got %h/%h want 01/01", SEG1, SEG0); else n_pass++;
    endtask

    task automatic test_random();
        logic g;
        logic v, inv, c, r;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        gen_seed(8'($urandom_range(1, 255)));
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 999) != 0);
            v   = ($urandom_range(0, 3) != 0);
            inv = ($urandom_range(0, 11) == 0);
            c   = ($urandom_range(0, 63) == 0);
            if (v) begin
                gen_next(g);
                step(r, 1'b1, g ^ inv, c);
            end else begin
                step(r, 1'b0, 1'($urandom_range(0, 1)), c);
            end
            n_checks++; if (locked !== m_locked || err_pulse !== m_pulse || err_cnt !== 8'(m_err))
                $display("FAIL rand cyc %0d: locked=%b pulse=%b cnt=%0d want %b/%b/%0d",
                         i, locked, err_pulse, err_cnt, m_locked, m_pulse, m_err); else n_pass++;
            n_checks++; if (SEG1 !== seg_ref[m_err[7:4]] || SEG0 !== seg_ref[m_err[3:0]])
                $display("FAIL rand_seg cyc %0d: got %h/%h want %h/%h",
                         i, SEG1, SEG0, seg_ref[m_err[7:4]], seg_ref[m_err[3:0]]); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clr_err = 1'b0;
        test_reset();
        test_lock();
        test_single_error();
        test_loss_of_lock();
        test_reset_mid_verify();
        test_zero_stream();
        test_saturation_clear_gaps();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
